riscv_lsu: RTL and testbench
============================

Name: riscv_lsu

Overview:
Load/store unit sitting directly downstream of the execute-stage ALU. It consumes the ALU's computed effective address (ALU_FUNC_ADD result) together with store data and funct3. It drives a single-port synchronous data BRAM, then returns a sign/zero-extended load result or a store completion to writeback. Multi-cycle, one outstanding access, with a valid/ready request handshake and a fault flag for misaligned or illegal accesses.

Parameters:
MEM_LATENCY, 2, BRAM read latency in cycles from the enable cycle to valid mem_rdata_in (legal range 1..7)

Ports:
clk_in  input  1  system clock, all state on rising edge
rst_in  input  1  asynchronous, active-high reset
req_valid_in  input  1  request present
req_ready_out  output  1  unit can accept a request this cycle
req_we_in  input  1  1=store, 0=load
req_func_in  input  3  RISC-V funct3 (LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010)
req_addr_in  input  32  byte effective address from the ALU
req_wdata_in  input  32  store data (rs2)
req_rd_in  input  5  destination register tag, returned unchanged
mem_en_out  output  1  BRAM enable
mem_we_out  output  4  per-byte write strobes
mem_addr_out  output  32  word-aligned byte address, {addr[31:2],2'b00}
mem_wdata_out  output  32  lane-aligned store data
mem_rdata_in  input  32  BRAM read word
rsp_valid_out  output  1  one-cycle completion pulse
rsp_data_out  output  32  load result; 0 for stores and faults
rsp_rd_out  output  5  captured tag
rsp_fault_out  output  1  misaligned or illegal access, valid with rsp_valid_out

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, DONE. req_ready_out = (state==IDLE) && !rst_in.
- IDLE: on req_valid_in&&req_ready_out, capture we/func/addr/wdata/rd.
  - Fault if any of: func illegal (load 011/110/111; store >=011); LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
  - Fault -> DONE. No memory access.
  - Otherwise -> ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_en_out=1, mem_addr_out from the captured address.
  - Store: mem_we_out and mem_wdata_out are driven, then -> DONE.
  - Load: mem_we_out=0, counter loaded with MEM_LATENCY, then -> WAIT.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle the counter equals 1 (ISSUE+MEM_LATENCY), sample mem_rdata_in, format it into rsp_data_out, then -> DONE.
- DONE (1 cycle): rsp_valid_out=1 with rsp_data/rd/fault held, then -> IDLE.
- Latency, counted from the accept edge to the rsp_valid_out cycle:
  - aligned load: MEM_LATENCY+2 cycles
  - store: 2 cycles
  - fault: 1 cycle
- Store lanes:
  - SB: we=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}
  - SH: we=4'b0011<<{addr[1],1'b0}, wdata={2{wdata[15:0]}}
  - SW: we=4'b1111, wdata=wdata
- Load extract: word shifted right by 8*addr[1:0].
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- mem_en_out and mem_we_out are 0 in every state except ISSUE. mem_we_out is always 0 for loads.
- req_valid_in outside IDLE is ignored and not captured. The requester must hold the request until ready.
- rsp_data_out, rsp_rd_out and rsp_fault_out hold their last values between responses.
- Reset:
  - All outputs go to 0 asynchronously and the state goes to IDLE.
  - Reset mid-access (ISSUE/WAIT/DONE) aborts immediately: mem_en_out and mem_we_out drop, and no rsp_valid_out is produced.
  - req_ready_out goes to 1 in the first cycle after deassertion.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF -> ISSUE cycle shows en=1, we=1111, addr=0x100, wdata=0xDEADBEEF. Then rsp_valid=1, fault=0, data=0, 2 cycles after accept.
- SB addr=0x103, wdata=0x000000A5 -> we=1000, wdata=0xA5A5A5A5. Then LB 0x103 with BRAM word 0xA5000000 -> rsp_data=0xFFFFFFA5; LBU -> 0x000000A5. Both loads respond MEM_LATENCY+2 cycles after accept.
- LH addr=0x102, word 0x8001_1234 -> 0xFFFF8001. LHU gives 0x00008001. With MEM_LATENCY=1, rsp arrives 3 cycles after accept.
- LW addr=0x101; SH addr=0x001; funct3=011 load -> each gives fault=1, data=0, no mem_en pulse, rsp 1 cycle after accept.
- Back-to-back: hold req_valid_in high with two loads -> second accepted only after rsp of the first (ready low through ISSUE/WAIT/DONE). rd tags 5 then 7 are returned in order.
- Assert rst_in during WAIT of a load -> mem_en/we=0 immediately, no rsp_valid ever, ready=1 the first cycle after release.

Source files
------------

// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between the execute-stage ALU and a single-port
// synchronous data BRAM. One outstanding access at a time, valid/ready request
// side, one-cycle response pulse with sign/zero-extended load data or a fault.
//
// state | meaning
// IDLE  | ready for a request; decode faults at accept
// ISSUE | one-cycle BRAM enable (write strobes for stores)
// WAIT  | load only: count down BRAM read latency, sample data at count 1
// DONE  | one-cycle response pulse, then back to IDLE
module riscv_lsu #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        req_we_in,
    input  logic [2:0]  req_func_in,
    input  logic [31:0] req_addr_in,
    input  logic [31:0] req_wdata_in,
    input  logic [4:0]  req_rd_in,
    output logic        mem_en_out,
    output logic [3:0]  mem_we_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_wdata_out,
    input  logic [31:0] mem_rdata_in,
    output logic        rsp_valid_out,
    output logic [31:0] rsp_data_out,
    output logic [4:0]  rsp_rd_out,
    output logic        rsp_fault_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_we;
    logic [2:0]  r_func;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [4:0]  r_rd;
    logic [2:0]  r_cnt;

    logic [31:0] r_rsp_data;
    logic [4:0]  r_rsp_rd;
    logic        r_rsp_fault;

    logic        w_accept;
    logic        w_func_bad;
    logic        w_misalign;
    logic        w_fault;
    logic [3:0]  w_strb;
    logic [31:0] w_lane_data;
    logic [31:0] w_shifted;
    logic [31:0] w_load_data;

    assign req_ready_out = (r_state == S_IDLE) && !rst_in;
    assign w_accept      = req_valid_in && req_ready_out;
    assign rsp_valid_out = (r_state == S_DONE);
    assign rsp_data_out  = r_rsp_data;
    assign rsp_rd_out    = r_rsp_rd;
    assign rsp_fault_out = r_rsp_fault;

    // Decode illegal funct3 and misalignment straight from the request inputs.
    always_comb begin
        w_func_bad = 1'b0;
        w_misalign = 1'b0;
        if (req_we_in) begin
            w_func_bad = (req_func_in >= 3'b011);
        end else begin
            w_func_bad = (req_func_in == 3'b011) || (req_func_in[2:1] == 2'b11);
        end
        if ((req_func_in[1:0] == 2'b01) && req_addr_in[0]) begin
            w_misalign = 1'b1;
        end
        if ((req_func_in[1:0] == 2'b10) && (req_addr_in[1:0] != 2'b00)) begin
            w_misalign = 1'b1;
        end
        w_fault = w_func_bad || w_misalign;
    end

    // Store lane steering: replicate the byte/half across the word, strobe the target lanes.
    always_comb begin
        w_strb      = 4'b1111;
        w_lane_data = r_wdata;
        case (r_func[1:0])
            2'b00: begin
                w_strb      = 4'b0001 << r_addr[1:0];
                w_lane_data = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_strb      = 4'b0011 << {r_addr[1], 1'b0};
                w_lane_data = {2{r_wdata[15:0]}};
            end
            default: begin
                w_strb      = 4'b1111;
                w_lane_data = r_wdata;
            end
        endcase
    end

    // Load extract: shift the addressed byte/half down to bit 0, then extend.
    always_comb begin
        w_shifted   = mem_rdata_in >> {r_addr[1:0], 3'b000};
        w_load_data = w_shifted;
        case (r_func)
            3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
            3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and BRAM-side outputs; memory is only touched in ISSUE.
    always_comb begin
        w_next        = r_state;
        mem_en_out    = 1'b0;
        mem_we_out    = 4'b0000;
        mem_addr_out  = {r_addr[31:2], 2'b00};
        mem_wdata_out = w_lane_data;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_fault ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_en_out = 1'b1;
                if (r_we) begin
                    mem_we_out = w_strb;
                    w_next     = S_DONE;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 3'd1) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Request capture, latency counter and response registers (held between responses).
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_we        <= 1'b0;
            r_func      <= 3'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_rd        <= 5'd0;
            r_cnt       <= 3'd0;
            r_rsp_data  <= 32'd0;
            r_rsp_rd    <= 5'd0;
            r_rsp_fault <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we    <= req_we_in;
                        r_func  <= req_func_in;
                        r_addr  <= req_addr_in;
                        r_wdata <= req_wdata_in;
                        r_rd    <= req_rd_in;
                        if (w_fault) begin
                            r_rsp_data  <= 32'd0;
                            r_rsp_rd    <= req_rd_in;
                            r_rsp_fault <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (r_we) begin
                        r_rsp_data  <= 32'd0;
                        r_rsp_rd    <= r_rd;
                        r_rsp_fault <= 1'b0;
                    end else begin
                        r_cnt <= 3'(MEM_LATENCY);
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_rsp_data  <= w_load_data;
                        r_rsp_rd    <= r_rd;
                        r_rsp_fault <= 1'b0;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: one instance with MEM_LATENCY=2 and one with
// MEM_LATENCY=1, each backed by a small latency-accurate BRAM model that
// returns a poison word outside the valid read cycle.
module tb_riscv_lsu;

    logic        clk;
    logic        rst;
    bit          sel_b;

    logic        r_valid;
    logic        r_we;
    logic [2:0]  r_func;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [4:0]  r_rd;

    logic        valid_a, ready_a, en_a, rsp_v_a, rsp_f_a;
    logic [3:0]  mwe_a;
    logic [31:0] maddr_a, mwdata_a, rdata_a, rsp_d_a;
    logic [4:0]  rsp_rd_a;

    logic        valid_b, ready_b, en_b, rsp_v_b, rsp_f_b;
    logic [3:0]  mwe_b;
    logic [31:0] maddr_b, mwdata_b, rdata_b, rsp_d_b;
    logic [4:0]  rsp_rd_b;

    int checks   = 0;
    int failures = 0;

    assign valid_a = r_valid && !sel_b;
    assign valid_b = r_valid && sel_b;

    riscv_lsu #(.MEM_LATENCY(2)) dut_a (
        .clk_in(clk), .rst_in(rst),
        .req_valid_in(valid_a), .req_ready_out(ready_a),
        .req_we_in(r_we), .req_func_in(r_func), .req_addr_in(r_addr),
        .req_wdata_in(r_wdata), .req_rd_in(r_rd),
        .mem_en_out(en_a), .mem_we_out(mwe_a), .mem_addr_out(maddr_a),
        .mem_wdata_out(mwdata_a), .mem_rdata_in(rdata_a),
        .rsp_valid_out(rsp_v_a), .rsp_data_out(rsp_d_a),
        .rsp_rd_out(rsp_rd_a), .rsp_fault_out(rsp_f_a)
    );

    riscv_lsu #(.MEM_LATENCY(1)) dut_b (
        .clk_in(clk), .rst_in(rst),
        .req_valid_in(valid_b), .req_ready_out(ready_b),
        .req_we_in(r_we), .req_func_in(r_func), .req_addr_in(r_addr),
        .req_wdata_in(r_wdata), .req_rd_in(r_rd),
        .mem_en_out(en_b), .mem_we_out(mwe_b), .mem_addr_out(maddr_b),
        .mem_wdata_out(mwdata_b), .mem_rdata_in(rdata_b),
        .rsp_valid_out(rsp_v_b), .rsp_data_out(rsp_d_b),
        .rsp_rd_out(rsp_rd_b), .rsp_fault_out(rsp_f_b)
    );

    logic        cur_ready, cur_en, cur_rspv, cur_fault;
    logic [3:0]  cur_we;
    logic [31:0] cur_addr, cur_wdata, cur_data;
    logic [4:0]  cur_rd;
    assign cur_ready = sel_b ? ready_b  : ready_a;
    assign cur_en    = sel_b ? en_b     : en_a;
    assign cur_rspv  = sel_b ? rsp_v_b  : rsp_v_a;
    assign cur_fault = sel_b ? rsp_f_b  : rsp_f_a;
    assign cur_we    = sel_b ? mwe_b    : mwe_a;
    assign cur_addr  = sel_b ? maddr_b  : maddr_a;
    assign cur_wdata = sel_b ? mwdata_b : mwdata_a;
    assign cur_data  = sel_b ? rsp_d_b  : rsp_d_a;
    assign cur_rd    = sel_b ? rsp_rd_b : rsp_rd_a;

    always #5 clk = ~clk;

    // BRAM model, read latency 2
    logic [31:0] mem_a [0:255];
    logic [31:0] rd_a1, rd_a2;
    logic        v_a1, v_a2;
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 256; k++) mem_a[k] <= 32'd0;
            v_a1 <= 1'b0; v_a2 <= 1'b0; rd_a1 <= 32'd0; rd_a2 <= 32'd0;
        end else begin
            v_a1  <= en_a && (mwe_a == 4'd0);
            rd_a1 <= mem_a[maddr_a[9:2]];
            if (en_a)
                for (int k = 0; k < 4; k++)
                    if (mwe_a[k]) mem_a[maddr_a[9:2]][8*k +: 8] <= mwdata_a[8*k +: 8];
            v_a2  <= v_a1;
            rd_a2 <= rd_a1;
        end
    end
    assign rdata_a = v_a2 ? rd_a2 : 32'hBADBAD00;

    // BRAM model, read latency 1
    logic [31:0] mem_b [0:255];
    logic [31:0] rd_b1;
    logic        v_b1;
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 256; k++) mem_b[k] <= 32'd0;
            v_b1 <= 1'b0; rd_b1 <= 32'd0;
        end else begin
            v_b1  <= en_b && (mwe_b == 4'd0);
            rd_b1 <= mem_b[maddr_b[9:2]];
            if (en_b)
                for (int k = 0; k < 4; k++)
                    if (mwe_b[k]) mem_b[maddr_b[9:2]][8*k +: 8] <= mwdata_b[8*k +: 8];
        end
    end
    assign rdata_b = v_b1 ? rd_b1 : 32'hBADBAD00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    int          lat;
    logic        saw_en;
    logic [3:0]  s_we;
    logic [31:0] s_addr, s_wdata;

    // Present one request, wait for acceptance, then count cycles to the response.
    task automatic do_req(input logic we, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd);
        @(negedge clk);
        chk("ready_before_req", 32'(cur_ready), 32'd1);
        r_valid = 1'b1; r_we = we; r_func = f; r_addr = a; r_wdata = wd; r_rd = rd;
        @(posedge clk);
        lat = 0; saw_en = 1'b0; s_we = 4'd0; s_addr = 32'd0; s_wdata = 32'd0;
        do begin
            @(negedge clk);
            r_valid = 1'b0;
            lat++;
            if (cur_en) begin
                saw_en = 1'b1; s_we = cur_we; s_addr = cur_addr; s_wdata = cur_wdata;
            end
        end while (!cur_rspv && lat < 20);
        chk("rsp_valid_seen", 32'(cur_rspv), 32'd1);
    endtask

    logic [9:0] ready_mask, rsp_mask;
    logic [4:0] rd_first, rd_second;
    logic       saw_rsp;

    initial begin
        clk = 1'b0; rst = 1'b1; sel_b = 1'b0;
        r_valid = 1'b0; r_we = 1'b0; r_func = 3'd0; r_addr = 32'd0; r_wdata = 32'd0; r_rd = 5'd0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready_a), 32'd0);
        chk("rst_en", 32'(en_a), 32'd0);
        chk("rst_rspv", 32'(rsp_v_a), 32'd0);
        chk("rst_data", rsp_d_a, 32'd0);
        rst = 1'b0;
        #1 chk("post_rst_ready", 32'(ready_a), 32'd1);

        // SW 0x100
        do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd3);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_en", 32'(saw_en), 32'd1);
        chk("sw_we", 32'(s_we), 32'hF);
        chk("sw_addr", s_addr, 32'h100);
        chk("sw_wdata", s_wdata, 32'hDEADBEEF);
        chk("sw_fault", 32'(cur_fault), 32'd0);
        chk("sw_data", cur_data, 32'd0);
        chk("sw_rd", 32'(cur_rd), 32'd3);

        // SB 0x103 -> word becomes 0xA5ADBEEF
        do_req(1'b1, 3'b000, 32'h103, 32'h000000A5, 5'd4);
        chk("sb_lat", 32'(lat), 32'd2);
        chk("sb_we", 32'(s_we), 32'h8);
        chk("sb_addr", s_addr, 32'h100);
        chk("sb_wdata", s_wdata, 32'hA5A5A5A5);

        do_req(1'b0, 3'b000, 32'h103, 32'd0, 5'd5);
        chk("lb_lat", 32'(lat), 32'd4);
        chk("lb_we", 32'(s_we), 32'd0);
        chk("lb_data", cur_data, 32'hFFFFFFA5);
        chk("lb_rd", 32'(cur_rd), 32'd5);

        do_req(1'b0, 3'b100, 32'h103, 32'd0, 5'd6);
        chk("lbu_lat", 32'(lat), 32'd4);
        chk("lbu_data", cur_data, 32'h000000A5);

        do_req(1'b0, 3'b000, 32'h101, 32'd0, 5'd6);
        chk("lb1_data", cur_data, 32'hFFFFFFBE);

        do_req(1'b0, 3'b101, 32'h100, 32'd0, 5'd6);
        chk("lhu0_data", cur_data, 32'h0000BEEF);

        do_req(1'b0, 3'b010, 32'h100, 32'd0, 5'd8);
        chk("lw_data", cur_data, 32'hA5ADBEEF);
        chk("lw_lat", 32'(lat), 32'd4);

        // SH upper half at 0x202
        do_req(1'b1, 3'b001, 32'h202, 32'h00008001, 5'd2);
        chk("sh_we", 32'(s_we), 32'hC);
        chk("sh_wdata", s_wdata, 32'h80018001);
        chk("sh_addr", s_addr, 32'h200);

        do_req(1'b0, 3'b001, 32'h202, 32'd0, 5'd2);
        chk("lh_hi_data", cur_data, 32'hFFFF8001);

        // faults
        do_req(1'b0, 3'b010, 32'h101, 32'd0, 5'd9);
        chk("f_lw_lat", 32'(lat), 32'd1);
        chk("f_lw_fault", 32'(cur_fault), 32'd1);
        chk("f_lw_data", cur_data, 32'd0);
        chk("f_lw_en", 32'(saw_en), 32'd0);
        chk("f_lw_rd", 32'(cur_rd), 32'd9);

        do_req(1'b1, 3'b001, 32'h001, 32'h1234, 5'd10);
        chk("f_sh_lat", 32'(lat), 32'd1);
        chk("f_sh_fault", 32'(cur_fault), 32'd1);
        chk("f_sh_en", 32'(saw_en), 32'd0);

        do_req(1'b0, 3'b011, 32'h100, 32'd0, 5'd11);
        chk("f_ld011_lat", 32'(lat), 32'd1);
        chk("f_ld011_fault", 32'(cur_fault), 32'd1);
        chk("f_ld011_en", 32'(saw_en), 32'd0);

        do_req(1'b1, 3'b100, 32'h100, 32'd0, 5'd12);
        chk("f_st100_fault", 32'(cur_fault), 32'd1);

        do_req(1'b0, 3'b101, 32'h103, 32'd0, 5'd13);
        chk("f_lhu_fault", 32'(cur_fault), 32'd1);

        do_req(1'b0, 3'b100, 32'h103, 32'd0, 5'd14);
        chk("after_f_fault", 32'(cur_fault), 32'd0);
        chk("after_f_data", cur_data, 32'h000000A5);

        // MEM_LATENCY=1 instance
        sel_b = 1'b1;
        do_req(1'b1, 3'b010, 32'h100, 32'h80011234, 5'd1);
        chk("b_sw_lat", 32'(lat), 32'd2);
        do_req(1'b0, 3'b001, 32'h102, 32'd0, 5'd15);
        chk("b_lh_lat", 32'(lat), 32'd3);
        chk("b_lh_data", cur_data, 32'hFFFF8001);
        do_req(1'b0, 3'b101, 32'h102, 32'd0, 5'd16);
        chk("b_lhu_lat", 32'(lat), 32'd3);
        chk("b_lhu_data", cur_data, 32'h00008001);
        sel_b = 1'b0;

        // back-to-back loads with valid held high
        @(negedge clk);
        r_valid = 1'b1; r_we = 1'b0; r_func = 3'b010; r_addr = 32'h100; r_rd = 5'd5;
        ready_mask = 10'd0; rsp_mask = 10'd0; rd_first = 5'd0; rd_second = 5'd0;
        @(posedge clk);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 1) r_rd = 5'd7;
            if (i == 6) r_valid = 1'b0;
            ready_mask[i] = ready_a;
            rsp_mask[i]   = rsp_v_a;
            if (rsp_v_a && i == 4) rd_first = rsp_rd_a;
            if (rsp_v_a && i == 9) rd_second = rsp_rd_a;
        end
        chk("b2b_ready_mask", 32'(ready_mask), 32'h020);
        chk("b2b_rsp_mask", 32'(rsp_mask), 32'h210);
        chk("b2b_rd_first", 32'(rd_first), 32'd5);
        chk("b2b_rd_second", 32'(rd_second), 32'd7);

        // reset during WAIT of a load
        @(negedge clk);
        r_valid = 1'b1; r_we = 1'b0; r_func = 3'b010; r_addr = 32'h100; r_rd = 5'd11;
        @(posedge clk);
        @(negedge clk);
        r_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rw_en", 32'(en_a), 32'd0);
        chk("rw_we", 32'(mwe_a), 32'd0);
        chk("rw_rspv", 32'(rsp_v_a), 32'd0);
        chk("rw_data", rsp_d_a, 32'd0);
        chk("rw_rd", 32'(rsp_rd_a), 32'd0);
        chk("rw_ready", 32'(ready_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rw_ready_after", 32'(ready_a), 32'd1);
        saw_rsp = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_v_a) saw_rsp = 1'b1;
        end
        chk("rw_no_rsp", 32'(saw_rsp), 32'd0);

        // reset during ISSUE of a store
        @(negedge clk);
        r_valid = 1'b1; r_we = 1'b1; r_func = 3'b010; r_addr = 32'h100; r_wdata = 32'h12345678; r_rd = 5'd3;
        @(posedge clk);
        #1;
        chk("ri_en_pre", 32'(en_a), 32'd1);
        chk("ri_we_pre", 32'(mwe_a), 32'hF);
        rst = 1'b1;
        #1;
        chk("ri_en", 32'(en_a), 32'd0);
        chk("ri_we", 32'(mwe_a), 32'd0);
        @(negedge clk);
        r_valid = 1'b0;
        rst = 1'b0;
        saw_rsp = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_v_a) saw_rsp = 1'b1;
        end
        chk("ri_no_rsp", 32'(saw_rsp), 32'd0);
        chk("ri_ready", 32'(ready_a), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
